seq_sub64: RTL and testbench



---
 rtl/seq_sub_pkg.sv | 22 ++
 rtl/sub_8bit.sv | 28 ++
 rtl/seq_sub64.sv | 120 ++++++++++++
 tb/tb_seq_sub64.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_sub_pkg.sv
// Shared types and defaults for the sequential subtractor.
// Optional feature macro used by seq_sub64: SEQ_SUB_OVF_EN (signed overflow output).
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 8;

  // Index width for a slice counter over n slices; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NSLICE = DEF_WIDTH / DEF_SLICE;
  localparam int IDX_W  = idx_w(NSLICE);

endpackage

// File: rtl/sub_8bit.sv
// Combinational W-bit ripple-borrow subtractor: diff = a - b - bin.
// Built as a chain of full-subtractor cells; bout is the borrow out of the MSB cell.
module sub_8bit
  import seq_sub_pkg::*;
#(
  parameter int W = DEF_SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  // brw[i] is the borrow into cell i
  logic [W:0] brw;

  assign brw[0] = bin;

  // Full-subtractor cell per bit: borrow when a<b, or a==b with a borrow coming in
  for (genvar i = 0; i < W; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[W];

endmodule

// File: rtl/seq_sub64.sv
// Multi-cycle WIDTH-bit subtractor (a - b - bin) reusing one SLICE-bit slice
// over NSLICE cycles, with a start/done handshake.
// Optional macro SEQ_SUB_OVF_EN adds the registered signed-overflow output ovf.
module seq_sub64
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SEQ_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // WIDTH must be an integer multiple of SLICE.
  localparam int NS = WIDTH / SLICE;
  localparam int KW = idx_w(NS);
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             brw;

  int               off;
  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_diff;
  logic             s_bout;

  // Select the operand slice addressed by the current index
  always_comb begin
    off = int'(k) * SLICE;
    s_a = a_r[off +: SLICE];
    s_b = b_r[off +: SLICE];
  end

  sub_8bit #(
    .W(SLICE)
  ) u_slice (
    .a   (s_a),
    .b   (s_b),
    .bin (brw),
    .diff(s_diff),
    .bout(s_bout)
  );

  // Control FSM plus operand, borrow and result registers; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      a_r   <= '0;
      b_r   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Results from the previous operation stay put until a start is taken
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            brw   <= bin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // start is ignored here; operands are stable for the whole run
          diff[off +: SLICE] <= s_diff;
          brw                <= s_bout;
          if (k == K_LAST) begin
            k     <= '0;
            bout  <= s_bout;
`ifdef SEQ_SUB_OVF_EN
            // Differing operand signs and a result sign that left the minuend's sign
            ovf   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (s_diff[SLICE-1] ^ a_r[WIDTH-1]);
`endif
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          // One-cycle done pulse; a start seen now is dropped
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub64.sv
// Self-checking bench for seq_sub64: directed vectors, ignored starts,
// mid-run reset, held-start throughput and randomized operands against an
// arithmetic reference model. Define SEQ_SUB_OVF_EN to include ovf checks.
`timescale 1ns/1ps
module tb_seq_sub64;

  localparam int W = 64;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SEQ_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Results of the latest do_op call
  int           obs_lat;
  int           obs_busy;
  logic [W-1:0] obs_diff;
  logic         obs_bout;
  logic         obs_ovf;
  logic         post_done;
  logic         post_busy;

  always #5 clk = ~clk;

  seq_sub64 #(
    .WIDTH(64),
    .SLICE(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SEQ_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  // Reference: exact a - b - bin in W+1 bits; top bit is the unsigned borrow
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    return r;
  endfunction

  // Reference: signed result outside the W-bit two's-complement range
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
    logic [W+1:0] s;
    s = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y} - (W+2)'(bi);
    return !((s[W+1] == s[W]) && (s[W] == s[W-1]));
  endfunction

  // Issue one operation from IDLE (called #1 after an edge); returns #1 after the edge following done
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    obs_lat  = -1;
    obs_busy = 0;
    a = x; b = y; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) obs_busy++;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (busy) obs_busy++;
      if (done) begin
        obs_lat = c;
        break;
      end
    end
    obs_diff = diff;
    obs_bout = bout;
`ifdef SEQ_SUB_OVF_EN
    obs_ovf  = ovf;
`else
    obs_ovf  = 1'b0;
`endif
    @(posedge clk); #1;
    post_done = done;
    post_busy = busy;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== '0)   begin errors++; $display("FAIL reset_diff: got %h expected 0", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
`ifdef SEQ_SUB_OVF_EN
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W:0]   exp;
    va[0] = 64'd7;  vb[0] = 64'd3; vc[0] = 1'b0;
    va[1] = 64'd0;  vb[1] = 64'd1; vc[1] = 1'b0;
    va[2] = 64'd10; vb[2] = 64'd3; vc[2] = 1'b1;
    va[3] = 64'h00FF_00FF_00FF_00FF; vb[3] = 64'h00FF_00FF_00FF_00FF; vc[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i]);
      exp = ref_sub(va[i], vb[i], vc[i]);
      checks++; if (obs_lat !== 8) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 8", i, obs_lat); end
      checks++; if (obs_diff !== exp[W-1:0]) begin errors++; $display("FAIL dir%0d_diff: got %h expected %h", i, obs_diff, exp[W-1:0]); end
      checks++; if (obs_bout !== exp[W]) begin errors++; $display("FAIL dir%0d_bout: got %b expected %b", i, obs_bout, exp[W]); end
      checks++; if (obs_busy !== 9) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 9", i, obs_busy); end
      checks++; if (post_done !== 1'b0 || post_busy !== 1'b0) begin
        errors++; $display("FAIL dir%0d_after_done: got done=%b busy=%b expected 0 0", i, post_done, post_busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] x0, y0, x1, y1, x2, y2;
    logic [W:0]   exp0, exp2;
    logic         done8;
    logic [W-1:0] d8;
    x0 = 64'h1234_5678_9ABC_DEF0; y0 = 64'h0FED_CBA9_8765_4321;
    x1 = 64'hFFFF_0000_FFFF_0000; y1 = 64'h0000_0000_0000_0001;
    x2 = 64'h0000_0000_0000_0005; y2 = 64'h0000_0000_0000_0009;
    exp0 = ref_sub(x0, y0, 1'b1);
    exp2 = ref_sub(x2, y2, 1'b0);
    done8 = 1'b0; d8 = '0;
    a = x0; b = y0; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin a = x1; b = y1; bin = 1'b0; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (c == 8) begin
        done8 = done; d8 = diff;
        a = x2; b = y2; bin = 1'b0; start = 1'b1;
      end
    end
    checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL ign_done_at_8: got %b expected 1", done8); end
    checks++; if (d8 !== exp0[W-1:0]) begin errors++; $display("FAIL ign_first_diff: got %h expected %h", d8, exp0[W-1:0]); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start_busy: got %b expected 0", busy); end
    checks++; if (diff !== exp0[W-1:0]) begin errors++; $display("FAIL ign_hold_diff: got %h expected %h", diff, exp0[W-1:0]); end
    checks++; if (bout !== exp0[W]) begin errors++; $display("FAIL ign_hold_bout: got %b expected %b", bout, exp0[W]); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_still_idle: got %b expected 0", busy); end
    do_op(x2, y2, 1'b0);
    checks++; if (obs_diff !== exp2[W-1:0] || obs_bout !== exp2[W]) begin
      errors++; $display("FAIL ign_next_op: got %h/%b expected %h/%b", obs_diff, obs_bout, exp2[W-1:0], exp2[W]);
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] x, y;
    logic [W:0]   exp;
    x = 64'hA5A5_A5A5_A5A5_A5A5; y = 64'h1111_2222_3333_4444;
    a = x; b = y; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++; if (diff !== '0 || bout !== 1'b0) begin
      errors++; $display("FAIL midrst_result: got %h/%b expected 0/0", diff, bout);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_resume_idle: got %b expected 0", busy); end
    exp = ref_sub(x, y, 1'b1);
    do_op(x, y, 1'b1);
    checks++; if (obs_lat !== 8 || obs_diff !== exp[W-1:0] || obs_bout !== exp[W]) begin
      errors++; $display("FAIL midrst_fresh_op: got lat=%0d %h/%b expected lat=8 %h/%b",
                        obs_lat, obs_diff, obs_bout, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, x2, y2, r1, r2;
    logic [W:0]   e1, e2;
    logic         b1, b2;
    int           d1, d2;
    x1 = {$urandom(), $urandom()}; y1 = {$urandom(), $urandom()};
    x2 = {$urandom(), $urandom()}; y2 = {$urandom(), $urandom()};
    e1 = ref_sub(x1, y1, 1'b0);
    e2 = ref_sub(x2, y2, 1'b1);
    d1 = -1; d2 = -1; r1 = '0; r2 = '0; b1 = 1'b0; b2 = 1'b0;
    a = x1; b = y1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = x2; b = y2; bin = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 10) start = 1'b0;
      if (done) begin
        if (d1 < 0) begin d1 = c; r1 = diff; b1 = bout; end
        else if (d2 < 0) begin d2 = c; r2 = diff; b2 = bout; end
      end
    end
    checks++; if (d1 !== 8 || d2 !== 18) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 8,18", d1, d2);
    end
    checks++; if (r1 !== e1[W-1:0] || b1 !== e1[W]) begin
      errors++; $display("FAIL b2b_first: got %h/%b expected %h/%b", r1, b1, e1[W-1:0], e1[W]);
    end
    checks++; if (r2 !== e2[W-1:0] || b2 !== e2[W]) begin
      errors++; $display("FAIL b2b_second: got %h/%b expected %h/%b", r2, b2, e2[W-1:0], e2[W]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic         bi;
    logic [W:0]   exp;
    int           gap;
    for (int i = 0; i < 40; i++) begin
      x  = {$urandom(), $urandom()};
      y  = {$urandom(), $urandom()};
      bi = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: y = x;
        1: x = '0;
        2: y = '1;
        default: ;
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      do_op(x, y, bi);
      exp = ref_sub(x, y, bi);
      checks++; if (obs_lat !== 8 || obs_diff !== exp[W-1:0] || obs_bout !== exp[W]) begin
        errors++; $display("FAIL rand%0d: got lat=%0d %h/%b expected lat=8 %h/%b (a=%h b=%h bin=%b)",
                          i, obs_lat, obs_diff, obs_bout, exp[W-1:0], exp[W], x, y, bi);
      end
`ifdef SEQ_SUB_OVF_EN
      checks++; if (obs_ovf !== ref_ovf(x, y, bi)) begin
        errors++; $display("FAIL rand%0d_ovf: got %b expected %b", i, obs_ovf, ref_ovf(x, y, bi));
      end
`endif
    end
  endtask

`ifdef SEQ_SUB_OVF_EN
  task automatic test_ovf();
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);
    checks++; if (obs_ovf !== ref_ovf(64'h8000_0000_0000_0000, 64'd1, 1'b0) || obs_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_min_minus_one: got %b expected 1", obs_ovf);
    end
    checks++; if (obs_bout !== 1'b0) begin errors++; $display("FAIL ovf_min_bout: got %b expected 0", obs_bout); end
    do_op(64'd5, 64'd3, 1'b0);
    checks++; if (obs_ovf !== 1'b0) begin errors++; $display("FAIL ovf_small: got %b expected 0", obs_ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
`ifdef SEQ_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
